mux_scan_ctrl: RTL

//  Upstream driver for the 8:1 bit-select mux. Accepts a DATA_W-bit word on a valid/ready port,

---
 rtl/mux_pkg.sv | 21 ++
 rtl/mux_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the bit-select mux scan controller.
//   SEL_W_DEF : default select width
//   GAP_W     : width of the inter-word idle counter (GAP range 0..15)
//   state_e   : scan controller FSM states
//   data_w()  : derives the data word width from the select width
package mux_pkg;

    localparam int unsigned SEL_W_DEF = 3;
    localparam int unsigned GAP_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int unsigned data_w(input int unsigned sel_w);
        return 32'(1) << sel_w;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Upstream driver for the 2**SEL_W:1 bit-select mux. Takes one word over a
// valid/ready port, holds it on mux_in and steps mux_sel through every index,
// one per clock, so the mux serialises the word.
// Ports:
//   clock, resetn          : clock, async active-low reset
//   s_valid/s_ready/s_data : word input handshake
//   stall                  : freezes scan progress while high
//   mux_in, mux_sel        : mux data word and select
//   scan_vld/first/last    : bit qualifier and word boundary markers
//   done                   : one-cycle pulse after the last bit of a word
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int unsigned SEL_W     = SEL_W_DEF,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned GAP       = 0,
    localparam int unsigned DATA_W   = data_w(SEL_W)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              stall,
    output logic [DATA_W-1:0] mux_in,
    output logic [SEL_W-1:0]  mux_sel,
    output logic              scan_vld,
    output logic              scan_first,
    output logic              scan_last,
    output logic              done
);

    localparam logic [SEL_W-1:0] CNT_LAST  = SEL_W'(DATA_W - 1);
    localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [DATA_W-1:0]   mux_in_q, mux_in_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                vld_q, vld_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                s_ready_c;
    logic                accept_c;

    // Ready is a decode of registered state (plus stall), held low in reset.
    always_comb begin
        s_ready_c = 1'b0;
        if (resetn) begin
            case (state_q)
                ST_IDLE: s_ready_c = 1'b1;
                ST_SCAN: s_ready_c = (cnt_q == CNT_LAST) && !stall && (GAP == 0);
                default: s_ready_c = 1'b0;
            endcase
        end
    end

    assign accept_c = s_valid && s_ready_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        mux_in_d = mux_in_q;
        sel_d    = sel_q;
        vld_d    = vld_q;
        first_d  = first_q;
        last_d   = last_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d  = ST_SCAN;
                    mux_in_d = s_data;
                    sel_d    = SEL_START;
                    cnt_d    = '0;
                    vld_d    = 1'b1;
                    first_d  = 1'b1;
                    last_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!stall) begin
                    if (cnt_q == CNT_LAST) begin
                        done_d = 1'b1;
                        if (accept_c) begin
                            // Reload without a bubble in scan_vld.
                            mux_in_d = s_data;
                            sel_d    = SEL_START;
                            cnt_d    = '0;
                            vld_d    = 1'b1;
                            first_d  = 1'b1;
                            last_d   = 1'b0;
                        end else begin
                            vld_d   = 1'b0;
                            first_d = 1'b0;
                            last_d  = 1'b0;
                            if (GAP > 0) begin
                                state_d = ST_GAP;
                                gap_d   = GAP_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        cnt_d   = cnt_q + SEL_W'(1);
                        sel_d   = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
                        first_d = 1'b0;
                        last_d  = ((cnt_q + SEL_W'(1)) == CNT_LAST);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            mux_in_q <= '0;
            sel_q    <= '0;
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            mux_in_q <= mux_in_d;
            sel_q    <= sel_d;
            vld_q    <= vld_d;
            first_q  <= first_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign s_ready    = s_ready_c;
    assign mux_in     = mux_in_q;
    assign mux_sel    = sel_q;
    assign scan_vld   = vld_q;
    assign scan_first = first_q;
    assign scan_last  = last_q;
    assign done       = done_q;

endmodule
